// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file front end.
//   XLEN     : register data width
//   AW       : register address width (32 registers)
//   ZERO_REG : architectural zero register (reads as 0, writes discarded)
//   state_t  : operand sequencer states
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage : regfile_pkg

// File: rtl/regfile_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_ctrl_if
// Bundles every bus signal of regfile_ctrl: operand request/response
// handshake, the two writeback requesters and the register-file port pins.
//   slave  : the controller side (regfile_ctrl)
//   master : the environment side (requesters, consumer, register file)
// ---------------------------------------------------------------------------
interface regfile_ctrl_if;
    import regfile_pkg::*;

    // operand request / response
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // writeback requesters (wb0 = ALU, wb1 = load unit)
    logic            wb0_valid;
    logic            wb0_ready;
    logic [AW-1:0]   wb0_addr;
    logic [XLEN-1:0] wb0_data;
    logic            wb1_valid;
    logic            wb1_ready;
    logic [AW-1:0]   wb1_addr;
    logic [XLEN-1:0] wb1_data;

    // register file pins
    logic [AW-1:0]   rf_read_addr;
    logic [XLEN-1:0] rf_data_out;
    logic            rf_write_enable;
    logic [AW-1:0]   rf_write_addr;
    logic [XLEN-1:0] rf_data_in;

    modport slave (
        input  req_valid, rs1_addr, rs2_addr, rsp_ready,
        input  wb0_valid, wb0_addr, wb0_data,
        input  wb1_valid, wb1_addr, wb1_data,
        input  rf_data_out,
        output req_ready, rsp_valid, rs1_data, rs2_data,
        output wb0_ready, wb1_ready,
        output rf_read_addr, rf_write_enable, rf_write_addr, rf_data_in
    );

    modport master (
        output req_valid, rs1_addr, rs2_addr, rsp_ready,
        output wb0_valid, wb0_addr, wb0_data,
        output wb1_valid, wb1_addr, wb1_data,
        output rf_data_out,
        input  req_ready, rsp_valid, rs1_data, rs2_data,
        input  wb0_ready, wb1_ready,
        input  rf_read_addr, rf_write_enable, rf_write_addr, rf_data_in
    );

endinterface : regfile_ctrl_if

// File: rtl/regfile_ctrl_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Two-way round-robin arbiter for the single register-file write port.
// The grant is combinational: the winner's ready and the write-port pins
// are driven in the same cycle the request is presented.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_valid    : per-requester write request
//   i_addr     : per-requester write address
//   i_data     : per-requester write data
//   o_ready    : per-requester grant (at most one set)
//   o_we       : write enable to the register file (never set for x0)
//   o_addr     : write address of the granted requester
//   o_data     : write data of the granted requester
// ---------------------------------------------------------------------------
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_valid,
    input  logic [1:0][AW-1:0]    i_addr,
    input  logic [1:0][XLEN-1:0]  i_data,
    output logic [1:0]            o_ready,
    output logic                  o_we,
    output logic [AW-1:0]         o_addr,
    output logic [XLEN-1:0]       o_data
);

    // Index of the requester that won the most recent contested cycle.
    // Starts at 1 so that wb0 wins the first tie.
    logic r_last;

    logic w_any;
    logic w_contested;
    logic w_sel;

    // Gating with rst_n keeps the write port silent for the whole time
    // reset is held, not just from the next clock edge.
    always_comb begin
        w_any       = rst_n & (|i_valid);
        w_contested = rst_n & (&i_valid);
        // Contested: alternate away from the last winner.
        // Uncontested: the only valid requester wins.
        w_sel       = w_contested ? ~r_last : i_valid[1];

        o_ready = '0;
        o_we    = 1'b0;
        o_addr  = '0;
        o_data  = '0;
        if (w_any) begin
            o_ready[w_sel] = 1'b1;
            o_addr         = i_addr[w_sel];
            o_data         = i_data[w_sel];
            // A write to x0 is acknowledged but never reaches the array.
            o_we           = (i_addr[w_sel] != ZERO_REG);
        end
    end

    // Pointer only moves on a contested grant, so a lone requester never
    // steals priority from the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_contested) begin
            r_last <= w_sel;
        end
    end

endmodule : wb_rr_arbiter

// File: rtl/regfile_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_ctrl
// Sequencer and write arbiter in front of a 32x32 register file that has one
// combinational read port and one clocked write port.
//   * Operand side: a (rs1, rs2) request is read through the single read
//     port over two cycles (RD1 then RD2) and held in RESP until taken.
//   * Write side: wb0/wb1 share the write port via wb_rr_arbiter.
//   * Captured operands snoop granted writes so the consumer always sees the
//     up-to-date register contents; x0 always reads as zero.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : regfile_ctrl_if.slave (request/response, writebacks, rf pins)
// ---------------------------------------------------------------------------
module regfile_ctrl
    import regfile_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    regfile_ctrl_if.slave  bus
);

    state_t r_state;
    state_t w_state_next;

    logic                 w_req_ready;
    logic                 w_accept;
    logic [AW-1:0]        w_rf_raddr;

    logic [1:0]           w_wb_ready;
    logic                 w_we;
    logic [AW-1:0]        w_waddr;
    logic [XLEN-1:0]      w_wdata;

    logic [1:0][AW-1:0]   w_req_addr;
    logic [1:0][AW-1:0]   w_op_addr;
    logic [1:0][XLEN-1:0] w_op_data;

    // -----------------------------------------------------------------
    // Write-port arbitration
    // -----------------------------------------------------------------
    wb_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid ({bus.wb1_valid, bus.wb0_valid}),
        .i_addr  ({bus.wb1_addr,  bus.wb0_addr}),
        .i_data  ({bus.wb1_data,  bus.wb0_data}),
        .o_ready (w_wb_ready),
        .o_we    (w_we),
        .o_addr  (w_waddr),
        .o_data  (w_wdata)
    );

    assign bus.wb0_ready       = w_wb_ready[0];
    assign bus.wb1_ready       = w_wb_ready[1];
    assign bus.rf_write_enable = w_we;
    assign bus.rf_write_addr   = w_waddr;
    assign bus.rf_data_in      = w_wdata;

    // -----------------------------------------------------------------
    // Operand sequencer FSM
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_rf_raddr   = '0;
        unique case (r_state)
            ST_IDLE: begin
                w_req_ready = rst_n;
                if (bus.req_valid) begin
                    w_state_next = ST_RD1;
                end
            end
            ST_RD1: begin
                w_rf_raddr   = w_op_addr[0];
                w_state_next = ST_RD2;
            end
            ST_RD2: begin
                w_rf_raddr   = w_op_addr[1];
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                // The handshake cycle doubles as the accept cycle for the
                // next request, giving one request every three cycles.
                if (bus.rsp_ready) begin
                    w_req_ready  = rst_n;
                    w_state_next = bus.req_valid ? ST_RD1 : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept         = w_req_ready & bus.req_valid;
    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = (r_state == ST_RESP);
    assign bus.rf_read_addr = w_rf_raddr;

    // -----------------------------------------------------------------
    // Operand registers: index 0 = rs1 (read in RD1), 1 = rs2 (read in RD2)
    // -----------------------------------------------------------------
    assign w_req_addr = {bus.rs2_addr, bus.rs1_addr};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            localparam state_t CAP_ST = (gi == 0) ? ST_RD1 : ST_RD2;

            logic [AW-1:0]   r_addr;
            logic [XLEN-1:0] r_data;
            logic            w_hit;
            logic [XLEN-1:0] w_cap;

            // w_we is already false for x0, so a hit is always a real write.
            assign w_hit = w_we && (w_waddr == r_addr);

            // On the capture cycle the array still holds the old value of a
            // register being written in the same cycle, so forward the
            // write data instead.
            assign w_cap = (r_addr == ZERO_REG) ? '0 :
                           (w_hit ? w_wdata : bus.rf_data_out);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_addr <= '0;
                end else if (w_accept) begin
                    r_addr <= w_req_addr[gi];
                end
            end

            // Outside the capture cycle, keep the operand coherent with any
            // write to its register. On an accept the address is about to
            // change, so snooping the old address would be pointless. A
            // snoop of rs2 during RD1 is overwritten by the RD2 capture.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (r_state == CAP_ST) begin
                    r_data <= w_cap;
                end else if ((r_state != ST_IDLE) && !w_accept && w_hit) begin
                    r_data <= w_wdata;
                end
            end

            assign w_op_addr[gi] = r_addr;
            assign w_op_data[gi] = r_data;
        end
    endgenerate

    assign bus.rs1_data = w_op_data[0];
    assign bus.rs2_data = w_op_data[1];

endmodule : regfile_ctrl

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_ctrl_if bus();

    regfile_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural register file: combinational read, clocked write.
    // x0 deliberately holds garbage so the controller must mask it.
    logic [31:0] mem [32] = '{0: 32'h0000_DEAD, default: 32'h0};
    assign bus.rf_data_out = mem[bus.rf_read_addr];
    always @(posedge clk) begin
        if (bus.rf_write_enable) mem[bus.rf_write_addr] <= bus.rf_data_in;
    end

    // ---------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------
    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
    } rsp_t;

    typedef struct {
        int          port;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        we;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    int   acc_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_rsp(input logic [31:0] d1, input logic [31:0] d2);
        rsp_t e;
        e.d1 = d1;
        e.d2 = d2;
        rsp_q.push_back(e);
    endtask

    task automatic push_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.port = p;
        e.addr = a;
        e.data = d;
        e.we   = (a != 5'd0);
        wr_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, decoupled from the stimulus.
    initial begin : monitor
        logic prev_rv;
        logic rdy;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_q.delete();
                prev_rv = 1'b0;
            end else begin
                if (bus.wb0_ready || bus.wb1_ready)
                    check("single_grant", 32'(bus.wb0_ready & bus.wb1_ready), 32'h0);
                for (int p = 0; p < 2; p++) begin
                    rdy = (p == 0) ? bus.wb0_ready : bus.wb1_ready;
                    if (rdy) begin
                        if (wr_q.size() == 0) begin
                            check("unexpected_grant_port", 32'(p), 32'hFFFF_FFFF);
                        end else begin
                            wr_t e;
                            e = wr_q.pop_front();
                            $display("wr  : wb%0d addr=%0d data=0x%08h we=%0b", p,
                                     bus.rf_write_addr, bus.rf_data_in, bus.rf_write_enable);
                            check("wr_port", 32'(p), 32'(e.port));
                            check("wr_we",   32'(bus.rf_write_enable), 32'(e.we));
                            check("wr_addr", 32'(bus.rf_write_addr), 32'(e.addr));
                            check("wr_data", bus.rf_data_in, e.data);
                        end
                    end
                end
                if (bus.rsp_valid && !prev_rv) begin
                    if (acc_q.size() == 0) begin
                        check("rsp_without_accept", 32'(bus.rsp_valid), 32'h0);
                    end else begin
                        int a;
                        a = acc_q.pop_front();
                        check("rsp_latency", 32'(cyc - a), 32'd3);
                    end
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_rsp", bus.rs1_data, 32'hFFFF_FFFF);
                    end else begin
                        rsp_t e;
                        e = rsp_q.pop_front();
                        $display("rsp : rs1=0x%08h rs2=0x%08h", bus.rs1_data, bus.rs2_data);
                        check("rsp_rs1", bus.rs1_data, e.d1);
                        check("rsp_rs2", bus.rs2_data, e.d2);
                    end
                end
                if (bus.req_valid && bus.req_ready) begin
                    $display("req : rs1=%0d rs2=%0d accepted at cycle %0d", bus.rs1_addr, bus.rs2_addr, cyc);
                    acc_q.push_back(cyc);
                end
                prev_rv = bus.rsp_valid;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    // Returns one step after the accept edge (FSM in RD1).
    task automatic do_req(input logic [4:0] a1, input logic [4:0] a2);
        int k;
        bus.req_valid = 1'b1;
        bus.rs1_addr  = a1;
        bus.rs2_addr  = a2;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        if (k == 50) check("req_accept_timeout", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wb_write(input int p, input logic [4:0] a, input logic [31:0] d);
        int  k;
        logic rdy;
        push_wr(p, a, d);
        if (p == 0) begin
            bus.wb0_valid = 1'b1; bus.wb0_addr = a; bus.wb0_data = d;
        end else begin
            bus.wb1_valid = 1'b1; bus.wb1_addr = a; bus.wb1_data = d;
        end
        rdy = 1'b0;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = (p == 0) ? bus.wb0_ready : bus.wb1_ready;
            if (rdy) break;
        end
        if (k == 50) check("wb_grant_timeout", 32'(rdy), 32'h1);
        @(posedge clk);
        #1;
        if (p == 0) bus.wb0_valid = 1'b0;
        else        bus.wb1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && wr_q.size() == 0) break;
        end
        check("queues_drained", 32'(rsp_q.size() + wr_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Directed tests
    // ---------------------------------------------------------------
    initial begin : stim
        bus.req_valid = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.rsp_ready = 1'b1;
        bus.wb0_valid = 1'b0; bus.wb0_addr = '0; bus.wb0_data = '0;
        bus.wb1_valid = 1'b0; bus.wb1_addr = '0; bus.wb1_data = '0;

        // Reset state, with live requests that must be ignored.
        bus.req_valid = 1'b1;
        bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd3; bus.wb0_data = 32'h33;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rs1_data",  bus.rs1_data, 32'h0);
        check("rst_rs2_data",  bus.rs2_data, 32'h0);
        check("rst_rf_we",     32'(bus.rf_write_enable), 32'h0);
        check("rst_rf_waddr",  32'(bus.rf_write_addr), 32'h0);
        check("rst_rf_wdata",  bus.rf_data_in, 32'h0);
        check("rst_rf_raddr",  32'(bus.rf_read_addr), 32'h0);
        check("rst_wb0_ready", 32'(bus.wb0_ready), 32'h0);
        bus.req_valid = 1'b0;
        bus.wb0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: preload x5/x6 through both write ports, then read them.
        wb_write(0, 5'd5, 32'h11);
        wb_write(1, 5'd6, 32'h22);
        push_rsp(32'h11, 32'h22);
        do_req(5'd5, 5'd6);
        @(negedge clk);
        check("raddr_rd1", 32'(bus.rf_read_addr), 32'd5);
        @(negedge clk);
        check("raddr_rd2", 32'(bus.rf_read_addr), 32'd6);
        wait_drain();

        // 2: x0 reads as zero even though the array holds garbage;
        //    a write to x0 is acknowledged without a write enable.
        push_rsp(32'h0, 32'h0);
        fork
            wb_write(0, 5'd0, 32'hFFFF);
            do_req(5'd0, 5'd0);
        join
        wait_drain();
        check("x0_array_untouched", mem[0], 32'h0000_DEAD);

        // 3: contested writes alternate starting with wb0.
        push_wr(0, 5'd1, 32'h100);
        push_wr(1, 5'd2, 32'h200);
        push_wr(0, 5'd1, 32'h100);
        push_wr(1, 5'd2, 32'h200);
        bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd1; bus.wb0_data = 32'h100;
        bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd2; bus.wb1_data = 32'h200;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        bus.wb0_valid = 1'b0;
        bus.wb1_valid = 1'b0;
        wait_drain();

        // 4: snoop: x7 written during RD1 and again while parked in RESP.
        bus.rsp_ready = 1'b0;
        push_rsp(32'h1234, 32'h1234);
        do_req(5'd7, 5'd7);
        wb_write(1, 5'd7, 32'hABCD);       // granted in RD1, returns in RD2
        @(posedge clk);                     // RD2 -> RESP
        #1;
        @(negedge clk);
        check("snoop_rd1_rs1", bus.rs1_data, 32'hABCD);
        check("snoop_rd1_rs2", bus.rs2_data, 32'hABCD);
        @(posedge clk);
        #1;
        wb_write(1, 5'd7, 32'h1234);        // granted in RESP, not handshaking
        bus.rsp_ready = 1'b1;
        wait_drain();

        // 5: hold the response for 5 cycles, then handshake and accept a
        //    new request in the same cycle.
        bus.rsp_ready = 1'b0;
        push_rsp(32'h100, 32'h200);
        do_req(5'd1, 5'd2);
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.rsp_valid) break;
            end
            if (k == 20) check("rsp_valid_timeout", 32'(bus.rsp_valid), 32'h1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            check("hold_rs1", bus.rs1_data, 32'h100);
            check("hold_rs2", bus.rs2_data, 32'h200);
        end
        @(posedge clk);
        #1;
        push_rsp(32'h11, 32'h22);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
        @(negedge clk);
        check("b2b_req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_rsp_valid_low", 32'(bus.rsp_valid), 32'h0);
        wait_drain();

        // 6: reset while in RD2 abandons the request; nothing is written
        //    while reset is held.
        do_req(5'd5, 5'd6);                 // now in RD1
        @(posedge clk);                     // RD1 -> RD2, rs1 captured
        #1;
        rst_n = 1'b0;
        bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd9; bus.wb0_data = 32'h99;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_rst_rs1",       bus.rs1_data, 32'h0);
        check("mid_rst_rs2",       bus.rs2_data, 32'h0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("mid_rst_raddr",     32'(bus.rf_read_addr), 32'h0);
        check("mid_rst_we",        32'(bus.rf_write_enable), 32'h0);
        check("mid_rst_wb0_ready", 32'(bus.wb0_ready), 32'h0);
        @(negedge clk);
        bus.wb0_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_no_write", mem[9], 32'h0);
        rst_n = 1'b1;
        push_rsp(32'h11, 32'h22);
        do_req(5'd5, 5'd6);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_ctrl

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Sequencer and arbiter in front of the 32x32 register file, which has one combinational read port and one clocked write port.
- Read side: accepts one two-operand request (rs1, rs2) and reads both operands through the single read port in consecutive cycles.
- Write side: shares the single write port between two writeback requesters (wb0 = ALU, wb1 = load unit) using round-robin arbitration.
- Enforces x0 semantics and keeps captured operands coherent with writes.

Parameters:
XLEN, 32, data width
AW, 5, register address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  operand request valid
req_ready  out  1  operand request accepted when valid&ready
rs1_addr  in  AW  first operand address
rs2_addr  in  AW  second operand address
rsp_valid  out  1  operands available
rsp_ready  in  1  consumer takes operands
rs1_data  out  XLEN  operand 1
rs2_data  out  XLEN  operand 2
wb0_valid / wb1_valid  in  1  write request
wb0_ready / wb1_ready  out  1  write granted this cycle
wb0_addr / wb1_addr  in  AW  write address
wb0_data / wb1_data  in  XLEN  write data
rf_read_addr  out  AW  to regfile read address
rf_data_out  in  XLEN  from regfile read data (combinational)
rf_write_enable  out  1  to regfile write enable
rf_write_addr  out  AW  to regfile write address
rf_data_in  out  XLEN  to regfile write data

Behaviour:
- FSM states: IDLE, RD1, RD2, RESP. Reset: IDLE.
- Reset values: req_ready=0 during reset; rsp_valid=0; rs1_data=rs2_data=0; rf_* outputs 0; latched addresses 0; rr pointer = 1 (wb0 wins the first tie).
- req_ready = (IDLE) | (RESP & rsp_ready). Acceptance latches rs1_addr/rs2_addr and moves to RD1.
- RD1: rf_read_addr = rs1; rs1_data captured at the edge; go to RD2.
- RD2: rf_read_addr = rs2; rs2_data captured at the edge; go to RESP.
- RESP: rsp_valid=1, operands stable.
  - rsp_ready & req_valid: accept the new request, go to RD1.
  - rsp_ready & !req_valid: go to IDLE.
  - Otherwise hold.
- Latency: accept edge E0 -> rsp_valid high after E2. Back-to-back throughput is 1 request per 3 cycles.
- rf_read_addr = 0 in IDLE and RESP.
- x0 on read: an operand address of 0 captures 0 regardless of rf_data_out.
- Write arbitration:
  - At most one grant per cycle.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted last; the pointer updates only on a contested grant.
  - A grant drives rf_write_enable / rf_write_addr / rf_data_in combinationally in the same cycle and asserts that requester's ready.
  - A requester holds its valid/addr/data until ready; ready never depends on the FSM state.
- x0 on write: a granted write to address 0 asserts ready but forces rf_write_enable=0.
- Bypass/snoop:
  - A granted nonzero write whose address matches a latched operand address updates the matching operand register at that edge.
  - Applies in RD1 (rs1 capture uses the write data instead of stale rf_data_out), RD2 (rs1 and rs2), and RESP while not handshaking (both).
  - Both operands with the same address are both updated.
  - Net effect: operands seen at the rsp handshake equal the regfile contents after all writes granted up to and including that cycle.
- Reset asserted mid-operation: the FSM returns to IDLE immediately, the request is abandoned, and no write is issued while rst_n=0.

Decomposition:
- Package regfile_pkg: XLEN, AW, ZERO_REG=0, FSM state enum.
- Sub-module wb_rr_arbiter: 2-way round-robin grant with pointer and x0 write suppression.
- The FSM, operand capture and snoop logic stay in regfile_ctrl.

Test Plan:
- Preload x5=0x11, x6=0x22; request rs1=5, rs2=6 -> rsp_valid 3 cycles after accept, rs1_data=0x11, rs2_data=0x22; rf_read_addr sequence 5 then 6.
- Request rs1=0, rs2=0 with x0 forcibly nonzero in memory; wb0 write addr 0 data 0xFFFF -> rs1_data=rs2_data=0; wb0_ready=1 with rf_write_enable=0.
- wb0 and wb1 both valid for 4 cycles (addr 1/2) -> grants alternate wb0,wb1,wb0,wb1; exactly one rf_write_enable per cycle.
- Request rs1=7, rs2=7; wb1 writes x7=0xABCD during RD1, then x7=0x1234 while in RESP with rsp_ready=0 -> at handshake rs1_data=rs2_data=0x1234.
- Hold rsp_ready=0 for 5 cycles, then assert it with a new req_valid -> operands stable throughout, new request accepted in the handshake cycle, rsp_valid low the next cycle.
- Assert rst_n=0 during RD2 -> rsp_valid=0, operands 0, state IDLE; after release, a fresh request completes normally.
